fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the number of queue entries; legal values are powers of two, 2..16.
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit, asynchronous active-low reset.
REQ-004 SHALL have port f_valid, input, 1 bit, meaning the fetch stage offers an entry this cycle.
REQ-005 SHALL have port f_pc, input, 32 bits, the PC of the offered instruction.
REQ-006 SHALL have port f_instr, input, 32 bits, the instruction word fetched at f_pc.
REQ-007 SHALL have port f_ready, output, 1 bit, meaning the queue accepts an entry this cycle; the PC stage freezes when it is low.
REQ-008 SHALL have port flush, input, 1 bit, meaning a redirect that discards all queued entries.
REQ-009 SHALL have port d_ready, input, 1 bit, meaning the decode stage consumes the head entry this cycle (deasserted on stall).
REQ-010 SHALL have port d_valid, output, 1 bit, meaning a head entry is present.
REQ-011 SHALL have port d_pc, output, 32 bits, the PC of the head entry.
REQ-012 SHALL have port d_instr, output, 32 bits, the instruction of the head entry.
REQ-013 SHALL have port count, output, log2(DEPTH)+1 bits, the number of occupied entries.

Function
REQ-014 SHALL implement a circular buffer of DEPTH {pc, instr} entries, with read pointer, write pointer and occupancy counter.
REQ-015 SHALL push on a rising edge when f_valid and f_ready are both high and flush is low: it writes at the write pointer and advances that pointer modulo DEPTH.
REQ-016 SHALL pop on a rising edge when d_valid and d_ready are both high and flush is low: it advances the read pointer modulo DEPTH.
REQ-017 SHALL drive f_ready = (count != DEPTH), combinationally from state only, with no dependence on d_ready (no full-queue bypass).
REQ-018 SHALL drive d_valid = (count != 0), combinationally from state only.
REQ-019 SHALL drive d_pc and d_instr from the entry at the read pointer when d_valid is high, and 32'h00000000 (nop) on both when the queue is empty.
REQ-020 SHALL have latency of one cycle: an entry pushed at edge N appears on d_* after edge N, with no combinational fall-through from f_* to d_*.
REQ-021 SHALL update count at each edge as follows:
- push only: count +1
- pop only: count -1
- push and pop together: count unchanged, both pointers advance
- neither: count held
REQ-022 SHALL allow simultaneous push and pop when count is between 1 and DEPTH-1, with both taking effect.
REQ-023 SHALL ignore the pop request when the queue is empty; only the push takes effect.
REQ-024 SHALL treat flush as synchronous and dominant: at the edge it sets count and both pointers to 0, and discards any push or pop requested in that cycle.
REQ-025 SHALL never let count exceed DEPTH or drop below 0 under any input sequence.
REQ-026 SHALL NOT require the storage array to be reset; the contents of unoccupied entries are don't-care and never visible on d_*.

Reset
REQ-027 SHALL, while reset is low, immediately and independent of clk, force count = 0, both pointers = 0, d_valid = 0, f_ready = 1, d_pc = 0 and d_instr = 0.
REQ-028 SHALL, when reset is asserted mid-operation, discard all queued entries, so no stale entry appears after release.
REQ-029 SHALL resume normal push/pop from the first rising edge after reset returns high.

Verification
REQ-030 SHALL be covered by a reset-then-push scenario: after reset, push pc=0x3000 with instr=0x3C010001 while d_ready=0 -> the next cycle shows d_valid=1, d_pc=0x3000, d_instr=0x3C010001, count=1.
REQ-031 SHALL be covered by a fill scenario (DEPTH=4): push pc 0x3000, 0x3004, 0x3008, 0x300C with d_ready=0 -> count=4 and f_ready=0; a fifth push at 0x3010 is ignored and the head stays 0x3000.
REQ-032 SHALL be covered by a streaming scenario: f_valid=1 and d_ready=1 continuously with PCs incrementing by 4 -> count stays 1, and d_pc lags f_pc by exactly one cycle.
REQ-033 SHALL be covered by a wrap scenario: 10 pushes and 10 pops interleaved in a 2-in/1-out pattern at DEPTH=4 -> pointers wrap and d_pc emerges in order 0x3000..0x3024 with no loss or duplication.
REQ-034 SHALL be covered by a flush scenario: with count=3, assert flush together with f_valid and d_ready -> the next cycle shows count=0, d_valid=0, d_instr=0, and neither the pushed entry nor the popped entry is kept.
REQ-035 SHALL be covered by an asynchronous reset scenario: drop reset between clock edges with count=2 -> count=0 and d_valid=0 before the next edge, and the first push after release appears at the head.

Source files
------------

// File: rtl/fetch_queue.sv
// Fetch queue: a small circular buffer decoupling the fetch stage from decode.
// Entries carry {pc, instr}; the head is presented one cycle after it is pushed,
// and a redirect (flush) empties the queue in a single edge.
module fetch_queue #(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     f_valid,
   input  logic [31:0]              f_pc,
   input  logic [31:0]              f_instr,
   output logic                     f_ready,
   input  logic                     flush,
   input  logic                     d_ready,
   output logic                     d_valid,
   output logic [31:0]              d_pc,
   output logic [31:0]              d_instr,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

   logic [31:0]   pc_mem    [DEPTH];
   logic [31:0]   instr_mem [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic          push;
   logic          pop;

   // Handshake flags come from occupancy alone so f_ready never depends on
   // d_ready; a flush cancels both push and pop for the cycle it is raised.
   always_comb begin
      f_ready = (count != FULL_COUNT);
      d_valid = (count != '0);
      push    = f_valid && f_ready && !flush;
      pop     = d_valid && d_ready && !flush;
   end

   // Head entry is visible only while occupied; an empty queue shows a nop.
   always_comb begin
      d_pc    = 32'h0000_0000;
      d_instr = 32'h0000_0000;
      if (d_valid) begin
         d_pc    = pc_mem[rd_ptr];
         d_instr = instr_mem[rd_ptr];
      end
   end

   // Storage needs no reset: unoccupied slots are never shown on the outputs.
   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem[wr_ptr]    <= f_pc;
         instr_mem[wr_ptr] <= f_instr;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two; flush and reset
   // both return the queue to empty, flush taking priority over push/pop.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// Testbench for fetch_queue: directed scenarios plus a randomized run, all
// checked against a queue-based reference model of the fetch buffer.
module tb_fetch_queue;

   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          clk;
   logic          reset;
   logic          f_valid;
   logic [31:0]   f_pc;
   logic [31:0]   f_instr;
   logic          f_ready;
   logic          flush;
   logic          d_ready;
   logic          d_valid;
   logic [31:0]   d_pc;
   logic [31:0]   d_instr;
   logic [CW-1:0] count;

   int n_checks = 0;
   int n_errors = 0;

   logic [63:0] model_q[$];

   fetch_queue #(.DEPTH(DEPTH)) dut (
      .clk     (clk),
      .reset   (reset),
      .f_valid (f_valid),
      .f_pc    (f_pc),
      .f_instr (f_instr),
      .f_ready (f_ready),
      .flush   (flush),
      .d_ready (d_ready),
      .d_valid (d_valid),
      .d_pc    (d_pc),
      .d_instr (d_instr),
      .count   (count)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [CW-1:0] exp_count();
      return CW'(model_q.size());
   endfunction

   function automatic logic [31:0] exp_pc();
      if (model_q.size() == 0) return 32'h0;
      return model_q[0][63:32];
   endfunction

   function automatic logic [31:0] exp_instr();
      if (model_q.size() == 0) return 32'h0;
      return model_q[0][31:0];
   endfunction

   // Drive inputs on the falling edge, away from the sampling edge.
   task automatic drive(input logic fv, input logic [31:0] pc, input logic [31:0] ins,
                        input logic dr, input logic fl);
      @(negedge clk);
      f_valid = fv;
      f_pc    = pc;
      f_instr = ins;
      d_ready = dr;
      flush   = fl;
   endtask

   // Advance one rising edge and update the reference model from the rules:
   // flush empties, otherwise pop from a non-empty queue and push into a non-full one.
   task automatic tick();
      logic do_push;
      logic do_pop;
      do_push = f_valid && (model_q.size() < DEPTH) && !flush;
      do_pop  = d_ready && (model_q.size() > 0) && !flush;
      @(posedge clk);
      if (flush) begin
         model_q.delete();
      end else begin
         if (do_pop) void'(model_q.pop_front());
         if (do_push) model_q.push_back({f_pc, f_instr});
      end
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset   = 1'b0;
      f_valid = 1'b0;
      d_ready = 1'b0;
      flush   = 1'b0;
      f_pc    = 32'h0;
      f_instr = 32'h0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      model_q.delete();
   endtask

   task automatic test_reset();
      reset   = 1'b0;
      f_valid = 1'b0;
      f_pc    = 32'h0;
      f_instr = 32'h0;
      d_ready = 1'b0;
      flush   = 1'b0;
      #2;
      n_checks++;
      if (count !== '0 || d_valid !== 1'b0 || f_ready !== 1'b1 || d_pc !== 32'h0 || d_instr !== 32'h0) begin
         n_errors++;
         $display("[TB] FAIL reset_state: count=%0d d_valid=%b f_ready=%b d_pc=%h d_instr=%h, required 0 0 1 0 0",
                  count, d_valid, f_ready, d_pc, d_instr);
      end
      @(negedge clk);
      reset = 1'b1;
      model_q.delete();
   endtask

   task automatic test_push_first();
      do_reset();
      drive(1'b1, 32'h3000, 32'h3C01_0001, 1'b0, 1'b0);
      tick();
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      n_checks++;
      if (d_valid !== 1'b1 || d_pc !== 32'h3000 || d_instr !== 32'h3C01_0001 || count !== CW'(1)) begin
         n_errors++;
         $display("[TB] FAIL push_first: d_valid=%b d_pc=%h d_instr=%h count=%0d, required 1 3000 3c010001 1",
                  d_valid, d_pc, d_instr, count);
      end
   endtask

   task automatic test_fill();
      do_reset();
      for (int i = 0; i < DEPTH; i++) begin
         drive(1'b1, 32'h3000 + 32'(4 * i), 32'hA000_0000 + 32'(i), 1'b0, 1'b0);
         tick();
      end
      drive(1'b1, 32'h3010, 32'hA000_0004, 1'b0, 1'b0);
      n_checks++;
      if (count !== CW'(DEPTH) || f_ready !== 1'b0) begin
         n_errors++;
         $display("[TB] FAIL fill_full: count=%0d f_ready=%b, required %0d 0", count, f_ready, DEPTH);
      end
      tick();
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      n_checks++;
      if (count !== CW'(DEPTH) || d_pc !== 32'h3000) begin
         n_errors++;
         $display("[TB] FAIL fill_overflow: count=%0d d_pc=%h, required %0d 3000", count, d_pc, DEPTH);
      end
      for (int i = 0; i < DEPTH; i++) begin
         drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
         n_checks++;
         if (d_pc !== 32'h3000 + 32'(4 * i) || d_instr !== 32'hA000_0000 + 32'(i)) begin
            n_errors++;
            $display("[TB] FAIL fill_drain: d_pc=%h d_instr=%h, required %h %h",
                     d_pc, d_instr, 32'h3000 + 32'(4 * i), 32'hA000_0000 + 32'(i));
         end
         tick();
      end
      n_checks++;
      if (d_valid !== 1'b0 || count !== '0) begin
         n_errors++;
         $display("[TB] FAIL fill_empty: d_valid=%b count=%0d, required 0 0", d_valid, count);
      end
   endtask

   task automatic test_stream();
      logic [31:0] pc;
      do_reset();
      pc = 32'h3000;
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, pc, pc ^ 32'h3C00_0000, 1'b1, 1'b0);
         tick();
         n_checks++;
         if (count !== CW'(1) || d_pc !== pc || d_instr !== (pc ^ 32'h3C00_0000)) begin
            n_errors++;
            $display("[TB] FAIL stream: count=%0d d_pc=%h, required 1 %h", count, d_pc, pc);
         end
         pc = pc + 32'd4;
      end
   endtask

   task automatic test_wrap();
      int pushed;
      int popped;
      int cyc;
      logic [31:0] exp;
      do_reset();
      pushed = 0;
      popped = 0;
      cyc    = 0;
      while ((pushed < 10 || popped < 10) && cyc < 80) begin
         drive(pushed < 10, 32'h3000 + 32'(4 * pushed), 32'hB000_0000 + 32'(pushed),
               (pushed >= 10) || (cyc % 2 == 1), 1'b0);
         if (d_ready && model_q.size() > 0) begin
            exp = 32'h3000 + 32'(4 * popped);
            n_checks++;
            if (d_pc !== exp || d_instr !== 32'hB000_0000 + 32'(popped)) begin
               n_errors++;
               $display("[TB] FAIL wrap_order: d_pc=%h d_instr=%h, required %h %h",
                        d_pc, d_instr, exp, 32'hB000_0000 + 32'(popped));
            end
            popped++;
         end
         if (f_valid && model_q.size() < DEPTH) pushed++;
         tick();
         cyc++;
      end
      n_checks++;
      if (popped != 10 || count !== '0 || d_valid !== 1'b0) begin
         n_errors++;
         $display("[TB] FAIL wrap_done: popped=%0d count=%0d d_valid=%b, required 10 0 0", popped, count, d_valid);
      end
   endtask

   task automatic test_flush();
      do_reset();
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 32'h4000 + 32'(4 * i), 32'hC000_0000 + 32'(i), 1'b0, 1'b0);
         tick();
      end
      drive(1'b1, 32'h400C, 32'hC000_0003, 1'b1, 1'b1);
      tick();
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      n_checks++;
      if (count !== '0 || d_valid !== 1'b0 || d_instr !== 32'h0 || d_pc !== 32'h0 || f_ready !== 1'b1) begin
         n_errors++;
         $display("[TB] FAIL flush_empty: count=%0d d_valid=%b d_pc=%h d_instr=%h, required 0 0 0 0",
                  count, d_valid, d_pc, d_instr);
      end
      drive(1'b1, 32'h8000, 32'hD000_0000, 1'b0, 1'b0);
      tick();
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      n_checks++;
      if (count !== CW'(1) || d_pc !== 32'h8000 || d_instr !== 32'hD000_0000) begin
         n_errors++;
         $display("[TB] FAIL flush_refill: count=%0d d_pc=%h, required 1 8000", count, d_pc);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 32'h6000 + 32'(4 * i), 32'hE000_0000 + 32'(i), 1'b0, 1'b0);
         tick();
      end
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      n_checks++;
      if (count !== CW'(2)) begin
         n_errors++;
         $display("[TB] FAIL async_pre: count=%0d, required 2", count);
      end
      #2;
      reset = 1'b0;
      #1;
      n_checks++;
      if (count !== '0 || d_valid !== 1'b0 || f_ready !== 1'b1 || d_pc !== 32'h0 || d_instr !== 32'h0) begin
         n_errors++;
         $display("[TB] FAIL async_reset: count=%0d d_valid=%b f_ready=%b d_pc=%h, required 0 0 1 0",
                  count, d_valid, f_ready, d_pc);
      end
      @(negedge clk);
      reset = 1'b1;
      model_q.delete();
      drive(1'b1, 32'h5000, 32'hF000_0001, 1'b0, 1'b0);
      tick();
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      n_checks++;
      if (count !== CW'(1) || d_pc !== 32'h5000 || d_instr !== 32'hF000_0001) begin
         n_errors++;
         $display("[TB] FAIL async_release: count=%0d d_pc=%h d_instr=%h, required 1 5000 f0000001",
                  count, d_pc, d_instr);
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 400; i++) begin
         drive(1'($urandom_range(0, 99) < 60), $urandom, $urandom,
               1'($urandom_range(0, 99) < 50), 1'($urandom_range(0, 29) == 0));
         tick();
         n_checks++;
         if (count !== exp_count() || d_valid !== (model_q.size() != 0) ||
             f_ready !== (model_q.size() != DEPTH) || d_pc !== exp_pc() || d_instr !== exp_instr()) begin
            n_errors++;
            $display("[TB] FAIL random cycle %0d: count=%0d d_valid=%b f_ready=%b d_pc=%h d_instr=%h, required %0d %b %b %h %h",
                     i, count, d_valid, f_ready, d_pc, d_instr, exp_count(), model_q.size() != 0,
                     model_q.size() != DEPTH, exp_pc(), exp_instr());
         end
      end
   endtask

   // Scenario sequence followed by the single summary line.
   initial begin
      test_reset();
      test_push_first();
      test_fill();
      test_stream();
      test_wrap();
      test_flush();
      test_async_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
